shared_bus_arb: RTL and testbench
=================================

# shared_bus_arb

Parametrised, registered successor to the datapath bus multiplexer. N sources request the bus. A round-robin arbiter grants exactly one owner at a time, and the owner's word is registered onto a single WIDTH-bit bus output. The bus output carries a valid flag. An optional hold limit forces rotation among competing sources. The block sits between the register file, special registers, memory data register and ALU result registers and the shared CPU bus, replacing per-source output strobes with request/grant handshakes.

## Interface
- `WIDTH`, 32, data width of each source and of the bus
- `N`, 24, number of sources, 1..64
- `MAX_HOLD`, 8, maximum consecutive grant cycles for one owner while others wait (only with the hold-limit configuration), ≥1
- `clk`  in  1  clock, all state on rising edge
- `clr`  in  1  synchronous, active-high reset
- `req`  in  N  per-source request; bit i requests the bus for source i
- `busi`  in  N*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH]
- `gnt`  out  N  one-hot grant (all-zero when idle), registered
- `owner`  out  max(1,clog2(N))  index of the current owner, registered
- `busy`  out  1  high while any grant is held
- `buso`  out  WIDTH  registered bus value
- `buso_valid`  out  1  high when `buso` holds data from a granted source

## Operation
- States: IDLE (no grant) and OWNED (one grant).
- Round-robin pointer `ptr`:
  - On every grant, `ptr` is set to owner+1, wrapping from N-1 to 0.
  - Search order is `ptr`, `ptr`+1, … mod N; the first set `req` bit wins.
- IDLE → OWNED:
  - Condition: any `req` bit is set.
  - `gnt`/`owner` load the winner and `busy` goes to 1.
- OWNED, `req[owner]` still high, no forced rotation: the grant is held.
- OWNED, `req[owner]` low:
  - If another `req` bit is set, the grant hands off directly to the next winner. `gnt` changes one-hot to one-hot with no all-zero cycle.
  - Otherwise the block returns to IDLE and `gnt` goes to 0.
- Data path:
  - Every cycle, `buso` is loaded with the `busi` slice selected by the registered `owner`, but only while `busy`=1.
  - `buso_valid` is `busy` delayed one cycle.
  - When not busy, `buso` holds its last value and is not zeroed.
- Requests from a source already granted are level-sensitive; no pulse is latched.
- Reset mid-operation: the next edge clears all state regardless of state or requests.
- N=1: `ptr` is constant 0, `owner` is 1 bit wide and always 0, and the grant is held for as long as `req[0]` is high.
- Reset values: `gnt`=0, `owner`=0, `busy`=0, `buso`=0, `buso_valid`=0. Internally, `ptr`=0 and the hold counter is 0.

## Timing
- `req` rises in cycle t → `gnt`/`busy` high at t+1 → `buso` = source data and `buso_valid`=1 at t+2.
- `req[owner]` falls in cycle t → `gnt` changes or clears at t+1 → `buso_valid` reflects this at t+2.
- On handoff, `buso_valid` stays continuously high. `buso` switches source one cycle after `gnt` switches.
- Throughput: one word per cycle, zero idle cycles between owners.

## Configuration
- `BUS_HOLD_LIMIT_EN` defined:
  - A hold counter increments each OWNED cycle and clears on every new grant.
  - When the counter reaches MAX_HOLD-1 and any other `req` bit is set, the next edge rotates the grant to the next winner even though `req[owner]` is still high.
  - With no competing request, the counter saturates and the grant is held.
- `BUS_HOLD_LIMIT_EN` undefined: no counter; an owner keeps the bus until it drops `req`. `MAX_HOLD` is ignored.

## Structure
- Package `bus_pkg`:
  - `bus_state_t` enum {IDLE, OWNED}
  - default `BUS_WIDTH`=32
  - index-width helper function returning max(1,clog2(N))
- Sub-module `rr_pick`:
  - Combinational masked round-robin priority picker.
  - Inputs: `req`, `ptr`. Outputs: `found`, `idx`.
  - Instantiated once and shared by the IDLE, handoff and forced-rotation paths.

## Test plan
Use N=4, WIDTH=32, MAX_HOLD=4.
1. Reset → after one `clr` edge with `req`=4'b1111, all outputs are 0. `clr` low with `req`=4'b0100 and `busi[2]`=32'hDEAD_BEEF → `gnt`=4'b0100 at t+1, `buso`=32'hDEAD_BEEF with `buso_valid`=1 at t+2.
2. Rotation: `req`=4'b1111 and each owner drops `req` after 1 cycle → grant order 0,1,2,3,0. `buso_valid` stays continuously 1, and `gnt` is never all-zero.
3. Wrap: source 3 owns, then releases while `req`=4'b0011 → next grant is source 0, not source 1.
4. Release to idle: the only owner drops `req` → `gnt`=0 and `busy`=0 next cycle, `buso_valid`=0 a cycle later, and `buso` holds its last value.
5. Hold limit, `BUS_HOLD_LIMIT_EN` defined: source 1 holds `req` with `req[2]` also high → `gnt` moves to 4'b0100 after 4 OWNED cycles. With only source 1 requesting, its grant is held for 20 cycles.
6. Reset mid-grant: `clr` asserted while `gnt`=4'b0010 → all outputs 0 next edge. After release, with `req`=4'b1010, the first grant is source 1 because `ptr` has restarted at 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the shared CPU bus arbiter.
//   bus_state_t : arbiter state (IDLE = no grant, OWNED = one grant held)
//   BUS_WIDTH   : default data width of each source and of the bus
//   idx_width() : width of an index into n sources, max(1, clog2(n))
package bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } bus_state_t;

  localparam int unsigned BUS_WIDTH = 32;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Scans req starting at ptr, then ptr+1, ... wrapping modulo N; the first set
// bit wins.
//   req   : per-source request vector
//   ptr   : index where the search starts (must be < N)
//   found : at least one request bit is set
//   idx   : index of the winning source (0 when nothing is found)
module rr_pick
  import bus_pkg::*;
#(
  parameter int unsigned N  = 24,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = ptr;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/shared_bus_arb.sv
// Registered round-robin arbiter and multiplexer for the shared CPU bus.
// N sources request the bus; exactly one owner is granted at a time and its
// word is registered onto buso.
//   clk        : clock, all state on rising edge
//   clr        : synchronous active-high reset
//   req        : per-source request (level-sensitive)
//   busi       : flattened source data, source i at [i*WIDTH +: WIDTH]
//   gnt        : one-hot grant, all-zero when idle (registered)
//   owner      : index of the current owner (registered)
//   busy       : a grant is held
//   buso       : registered bus value (holds when not busy)
//   buso_valid : buso carries data from a granted source (busy delayed 1)
// Optional feature macro: BUS_HOLD_LIMIT_EN -- forces rotation after MAX_HOLD
// consecutive owned cycles when another source is waiting.
module shared_bus_arb
  import bus_pkg::*;
#(
  parameter int unsigned WIDTH    = BUS_WIDTH,
  parameter int unsigned N        = 24,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [N-1:0]          req,
  input  logic [N*WIDTH-1:0]    busi,
  output logic [N-1:0]          gnt,
  output logic [idx_width(N)-1:0] owner,
  output logic                  busy,
  output logic [WIDTH-1:0]      buso,
  output logic                  buso_valid
);

  localparam int unsigned IW = idx_width(N);

  if (N < 1 || N > 64 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("shared_bus_arb: N must be 1..64 and MAX_HOLD >= 1");
  end

  bus_state_t    state, state_n;
  logic [N-1:0]  gnt_n;
  logic [IW-1:0] owner_n, ptr, ptr_n;
  logic          busy_n;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          take;
  logic          rotate;
  logic [WIDTH-1:0] sel;

  // One picker serves first grant, handoff and forced rotation: ptr always
  // sits at owner+1, so the current owner is searched last.
  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef BUS_HOLD_LIMIT_EN
  localparam int unsigned HW = idx_width(MAX_HOLD);
  logic [HW-1:0] hold_cnt, hold_cnt_n;

  always_comb begin
    rotate = (hold_cnt == HW'(MAX_HOLD - 1)) && (|(req & ~gnt));
  end

  always_comb begin
    hold_cnt_n = hold_cnt;
    if (take) begin
      hold_cnt_n = '0;
    end else if (state == OWNED && hold_cnt != HW'(MAX_HOLD - 1)) begin
      hold_cnt_n = hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) hold_cnt <= '0;
    else     hold_cnt <= hold_cnt_n;
  end
`else
  always_comb begin
    rotate = 1'b0;
  end
`endif

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    ptr_n   = ptr;
    busy_n  = busy;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) take = 1'b1;
      end
      OWNED: begin
        if (!req[owner] || rotate) begin
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (take) begin
      state_n           = OWNED;
      gnt_n             = '0;
      gnt_n[pick_idx]   = 1'b1;
      owner_n           = pick_idx;
      ptr_n             = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
      busy_n            = 1'b1;
    end
  end

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner == IW'(i)) sel = busi[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      gnt        <= '0;
      owner      <= '0;
      ptr        <= '0;
      busy       <= 1'b0;
      buso       <= '0;
      buso_valid <= 1'b0;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      owner      <= owner_n;
      ptr        <= ptr_n;
      busy       <= busy_n;
      if (busy) buso <= sel;
      buso_valid <= busy;
    end
  end

endmodule

// File: tb/tb_shared_bus_arb.sv
module tb_shared_bus_arb;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MH = 4;
`ifdef BUS_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           clr;
  logic [N-1:0]   req;
  logic [N*W-1:0] busi;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           busy;
  logic [W-1:0]   buso;
  logic           buso_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int           m_own;        // -1 when idle
  int           m_owner_out;
  int           m_ptr;
  int           m_cnt;
  logic [W-1:0] m_buso;
  bit           m_valid;

  always #5 clk = ~clk;

  shared_bus_arb #(.WIDTH(W), .N(N), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .clr        (clr),
    .req        (req),
    .busi       (busi),
    .gnt        (gnt),
    .owner      (owner),
    .busy       (busy),
    .buso       (buso),
    .buso_valid (buso_valid)
  );

  function automatic int search(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_own >= 0) g[m_own] = 1'b1;
    return g;
  endfunction

  task automatic model_grant(input int w);
    m_own       = w;
    m_owner_out = w;
    m_ptr       = (w + 1) % N;
    m_cnt       = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] nb;
    bit nv, others, rel, frc;
    int w;
    if (clr) begin
      m_own = -1; m_owner_out = 0; m_ptr = 0; m_cnt = 0;
      m_buso = '0; m_valid = 1'b0;
    end else begin
      nb = (m_own >= 0) ? busi[m_own*W +: W] : m_buso;
      nv = (m_own >= 0);
      if (m_own < 0) begin
        w = search(req, m_ptr);
        if (w >= 0) model_grant(w);
      end else begin
        others = 1'b0;
        for (int k = 0; k < N; k++) if (k != m_own && req[k]) others = 1'b1;
        rel = !req[m_own];
        frc = HOLD_EN && (m_cnt == MH - 1) && others;
        if (rel || frc) begin
          w = search(req, m_ptr);
          if (w >= 0) model_grant(w);
          else m_own = -1;
        end else if (m_cnt < MH - 1) begin
          m_cnt++;
        end
      end
      m_buso  = nb;
      m_valid = nv;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [W-1:0] v);
    busi[i*W +: W] = v;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_src(i, $urandom);
    step();
    n_cmp++; if (gnt !== 4'b0) begin n_bad++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL reset_owner got %0d want 0", owner); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (buso !== 32'h0) begin n_bad++; $display("FAIL reset_buso got %h want 0", buso); end
    n_cmp++; if (buso_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", buso_valid); end
    clr = 1'b0;
    req = 4'b0100;
    set_src(2, 32'hDEAD_BEEF);
    step();
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL first_gnt got %b want 0100", gnt); end
    n_cmp++; if (owner !== 2'd2) begin n_bad++; $display("FAIL first_owner got %0d want 2", owner); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL first_busy got %b want 1", busy); end
    step();
    n_cmp++; if (buso !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL first_buso got %h want deadbeef", buso); end
    n_cmp++; if (buso_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid got %b want 1", buso_valid); end
  endtask

  task automatic test_rotation();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] want;
    for (int i = 0; i < N; i++) set_src(i, 32'h1000_0000 + i);
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      want = 4'b0001 << order[k];
      n_cmp++; if (gnt !== want) begin n_bad++; $display("FAIL rot_gnt step %0d got %b want %b", k, gnt, want); end
      if (k >= 1) begin
        n_cmp++; if (buso_valid !== 1'b1) begin n_bad++; $display("FAIL rot_valid step %0d got %b want 1", k, buso_valid); end
        n_cmp++; if (buso !== 32'h1000_0000 + order[k-1]) begin
          n_bad++; $display("FAIL rot_buso step %0d got %h want %h", k, buso, 32'h1000_0000 + order[k-1]);
        end
      end
      req = ~(4'b0001 << order[k]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1000;
    step();
    n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL wrap_first got %b want 1000", gnt); end
    req = 4'b0011;
    step();
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_gnt got %b want 0001", gnt); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL wrap_owner got %0d want 0", owner); end
  endtask

  task automatic test_idle();
    set_src(0, 32'hCAFE_F00D);
    req = 4'b0001;
    step();
    n_cmp++; if (buso !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL idle_pre_buso got %h want cafef00d", buso); end
    req = 4'b0000;
    step();
    n_cmp++; if (gnt !== 4'b0) begin n_bad++; $display("FAIL idle_gnt got %b want 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
    n_cmp++; if (buso_valid !== 1'b1) begin n_bad++; $display("FAIL idle_valid_lag got %b want 1", buso_valid); end
    set_src(0, 32'h0BAD_0BAD);
    step();
    n_cmp++; if (buso_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid got %b want 0", buso_valid); end
    n_cmp++; if (buso !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL idle_hold got %h want cafef00d", buso); end
    step();
    n_cmp++; if (buso !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL idle_hold2 got %h want cafef00d", buso); end
  endtask

  task automatic test_hold_limit();
    logic [N-1:0] want;
    do_reset();
    req = 4'b0110;
`ifdef BUS_HOLD_LIMIT_EN
    for (int k = 1; k <= 5; k++) begin
      step();
      want = (k < 5) ? 4'b0010 : 4'b0100;
      n_cmp++; if (gnt !== want) begin n_bad++; $display("FAIL hold_rot step %0d got %b want %b", k, gnt, want); end
    end
    do_reset();
    req = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      step();
      n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL hold_solo step %0d got %b want 0010", k, gnt); end
    end
`else
    for (int k = 0; k < 10; k++) begin
      step();
      want = 4'b0010;
      n_cmp++; if (gnt !== want) begin n_bad++; $display("FAIL hold_keep step %0d got %b want %b", k, gnt, want); end
    end
`endif
  endtask

  task automatic test_midreset();
    do_reset();
    req = 4'b0010;
    step();
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL mid_pre got %b want 0010", gnt); end
    clr = 1'b1;
    step();
    n_cmp++; if (gnt !== 4'b0) begin n_bad++; $display("FAIL mid_gnt got %b want 0000", gnt); end
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL mid_owner got %0d want 0", owner); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
    n_cmp++; if (buso !== 32'h0) begin n_bad++; $display("FAIL mid_buso got %h want 0", buso); end
    n_cmp++; if (buso_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %b want 0", buso_valid); end
    clr = 1'b0;
    req = 4'b1010;
    step();
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL mid_restart got %b want 0010", gnt); end
    n_cmp++; if (owner !== 2'd1) begin n_bad++; $display("FAIL mid_restart_owner got %0d want 1", owner); end
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
        set_src(i, $urandom);
      end
      step();
      eg = exp_gnt();
      n_cmp++; if (gnt !== eg) begin n_bad++; $display("FAIL rnd_gnt cyc %0d got %b want %b", c, gnt, eg); end
      n_cmp++; if (owner !== 2'(m_owner_out)) begin n_bad++; $display("FAIL rnd_owner cyc %0d got %0d want %0d", c, owner, m_owner_out); end
      n_cmp++; if (busy !== (m_own >= 0)) begin n_bad++; $display("FAIL rnd_busy cyc %0d got %b want %b", c, busy, m_own >= 0); end
      n_cmp++; if (buso !== m_buso) begin n_bad++; $display("FAIL rnd_buso cyc %0d got %h want %h", c, buso, m_buso); end
      n_cmp++; if (buso_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, buso_valid, m_valid); end
    end
  endtask

  initial begin
    clr  = 1'b1;
    req  = '0;
    busi = '0;
    m_own = -1; m_owner_out = 0; m_ptr = 0; m_cnt = 0;
    m_buso = '0; m_valid = 1'b0;
    test_reset();
    test_rotation();
    test_wrap();
    test_idle();
    test_hold_limit();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
